mach_seq_ctrl: RTL and testbench

Sequencing controller for the 2-flip-flop state machine (outputs A,B, input x). On a start pulse it drives x=0 with stepping enabled for n0 cycles, idles for a fixed gap, then drives x=1 for n1 stepping cycles, and finally pulses done. While x=1 it counts the cycles in which the machine sits in a programmed target state, and it captures the final AB state. It replaces hand-written clock/x stimulus with a reusable, handshaked sequencer.

---
 rtl/mach_seq_ctrl_pkg.sv | 22 ++
 rtl/mach_phase_cnt.sv | 34 +++
 rtl/mach_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_mach_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mach_seq_ctrl_pkg.sv
// Shared definitions for the machine sequencing controller: FSM states,
// default sizing and the phase-counter width helper.
package mach_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH0  = 3'd1,
        S_GAP  = 3'd2,
        S_PH1  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int unsigned DEF_CNT_W   = 4;
    localparam int unsigned DEF_GAP_CYC = 1;

    // The phase counter also times the gap (up to 15 cycles), so it never
    // gets narrower than 4 bits even when CNT_W is.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/mach_phase_cnt.sv
// Loadable down-counter timing one sequencer phase; last_o is high while the
// count reads zero.
module mach_phase_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mach_seq_ctrl.sv
// Sequencer for the 2-flip-flop machine: x=0 stepping phase, idle gap, x=1
// stepping phase with target-state hit counting, then a one-cycle done.
module mach_seq_ctrl
    import mach_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n0,
    input  logic [CNT_W-1:0] n1,
    input  logic [1:0]       target,
    input  logic             state_a,
    input  logic             state_b,
    output logic             x,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       last_ab
);

    localparam int unsigned   CW     = cnt_width(CNT_W);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n1_q, hit_q;
    logic [1:0]       target_q, last_ab_q;
    logic [1:0]       ab;
    logic             accept, ph1_upd;
    logic             cnt_load, cnt_last;
    logic [CW-1:0]    cnt_val;

    assign ab      = {state_a, state_b};
    assign accept  = (state_q == S_IDLE) && start && !abort;
    assign ph1_upd = (state_q == S_PH1) && !abort;

    mach_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .value_i (cnt_val),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            S_IDLE: if (accept) begin
                cnt_load = 1'b1;
                if (n0 != '0) begin
                    state_d = S_PH0;
                    cnt_val = CW'(n0) - CW'(1);
                end else begin
                    state_d = S_GAP;
                    cnt_val = GAP_LD;
                end
            end
            S_PH0: if (cnt_last) begin
                state_d  = S_GAP;
                cnt_load = 1'b1;
                cnt_val  = GAP_LD;
            end
            S_GAP: if (cnt_last) begin
                if (n1_q != '0) begin
                    state_d  = S_PH1;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(n1_q) - CW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PH1:   if (cnt_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cnt_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // n0 only seeds the counter at start, so only n1 needs holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1_q      <= '0;
            target_q  <= '0;
            hit_q     <= '0;
            last_ab_q <= '0;
        end else if (accept) begin
            n1_q     <= n1;
            target_q <= target;
            hit_q    <= '0;
        end else if (ph1_upd) begin
            if ((ab == target_q) && (hit_q != '1)) begin
                hit_q <= hit_q + CNT_W'(1);
            end
            if (cnt_last) begin
                last_ab_q <= ab;
            end
        end
    end

    assign x       = (state_q == S_PH1);
    assign step_en = (state_q == S_PH0) || (state_q == S_PH1);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign hit_cnt = hit_q;
    assign last_ab = last_ab_q;

endmodule

// File: tb/tb_mach_seq_ctrl.sv
// Bench for mach_seq_ctrl: two instances (CNT_W=4/GAP=1 and CNT_W=2/GAP=3)
// checked every cycle against a position-in-sequence model.
module tb_mach_seq_ctrl;

    localparam int GAP_A = 1;
    localparam int GAP_B = 3;

    typedef struct {
        int active;
        int pos;
        int n0;
        int n1;
        int tgt;
        int hit;
        int last;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] n0 = '0;
    logic [3:0] n1 = '0;
    logic [1:0] target = '0;
    logic       mach_clr = 1'b0;
    logic [1:0] ab_a;
    logic [1:0] ab_b = '0;
    logic [1:0] n0_b, n1_b;

    logic       x_a, step_en_a, busy_a, done_a;
    logic [3:0] hit_a;
    logic [1:0] last_a;
    logic       x_b, step_en_b, busy_b, done_b;
    logic [1:0] hit_b;
    logic [1:0] last_b;

    int   n_chk = 0;
    int   n_pass = 0;
    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    assign n0_b = n0[1:0];
    assign n1_b = n1[1:0];

    always #5 clk = ~clk;

    mach_seq_ctrl #(.CNT_W(4), .GAP_CYC(GAP_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .n0(n0), .n1(n1), .target(target),
        .state_a(ab_a[1]), .state_b(ab_a[0]),
        .x(x_a), .step_en(step_en_a), .busy(busy_a), .done(done_a),
        .hit_cnt(hit_a), .last_ab(last_a)
    );

    mach_seq_ctrl #(.CNT_W(2), .GAP_CYC(GAP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .n0(n0_b), .n1(n1_b), .target(target),
        .state_a(ab_b[1]), .state_b(ab_b[0]),
        .x(x_b), .step_en(step_en_b), .busy(busy_b), .done(done_b),
        .hit_cnt(hit_b), .last_ab(last_b)
    );

    // Machine under A: 2-bit up-counter advancing on stepping x=1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ab_a <= '0;
        else if (mach_clr)           ab_a <= '0;
        else if (step_en_a && x_a)   ab_a <= ab_a + 2'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    endtask

    function automatic mdl_t mstep(input mdl_t m, input int st, input int ab_, input int v0,
                                   input int v1, input int tg, input int abv,
                                   input int gap, input int maxh);
        mdl_t r = m;
        int   p1 = m.n0 + gap;
        int   dn = m.n0 + gap + m.n1;
        if (m.active == 0) begin
            if (st != 0 && ab_ == 0) begin
                r.active = 1; r.pos = 0; r.n0 = v0; r.n1 = v1; r.tgt = tg; r.hit = 0;
            end
        end else if (ab_ != 0) begin
            r.active = 0;
        end else begin
            if (m.pos >= p1 && m.pos < dn) begin
                if (abv == m.tgt && m.hit < maxh) r.hit = m.hit + 1;
                if (m.pos == dn - 1) r.last = abv;
            end
            if (m.pos == dn) r.active = 0;
            else r.pos = m.pos + 1;
        end
        return r;
    endfunction

    function automatic int in_ph1(input mdl_t m, input int gap);
        return int'(m.active != 0 && m.pos >= m.n0 + gap && m.pos < m.n0 + gap + m.n1);
    endfunction

    function automatic int in_ph0(input mdl_t m);
        return int'(m.active != 0 && m.pos < m.n0);
    endfunction

    function automatic int in_done(input mdl_t m, input int gap);
        return int'(m.active != 0 && m.pos == m.n0 + gap + m.n1);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = mstep(ma, int'(start), int'(abort), int'(n0), int'(n1), int'(target),
                       int'(ab_a), GAP_A, 15);
            mb = mstep(mb, int'(start), int'(abort), int'(n0_b), int'(n1_b), int'(target),
                       int'(ab_b), GAP_B, 3);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("a_x",       int'(x_a),       in_ph1(ma, GAP_A));
            chk("a_step_en", int'(step_en_a), in_ph0(ma) | in_ph1(ma, GAP_A));
            chk("a_busy",    int'(busy_a),    ma.active);
            chk("a_done",    int'(done_a),    in_done(ma, GAP_A));
            chk("a_hit_cnt", int'(hit_a),     ma.hit);
            chk("a_last_ab", int'(last_a),    ma.last);
            chk("b_x",       int'(x_b),       in_ph1(mb, GAP_B));
            chk("b_step_en", int'(step_en_b), in_ph0(mb) | in_ph1(mb, GAP_B));
            chk("b_busy",    int'(busy_b),    mb.active);
            chk("b_done",    int'(done_b),    in_done(mb, GAP_B));
            chk("b_hit_cnt", int'(hit_b),     mb.hit);
            chk("b_last_ab", int'(last_b),    mb.last);
        end
    end

    // Called at a negedge; returns at the first negedge after the start edge.
    task automatic go(input int v0, input int v1, input int tg);
        start  = 1'b1;
        n0     = 4'(v0);
        n1     = 4'(v1);
        target = 2'(tg);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic clr_mach();
        mach_clr = 1'b1;
        @(negedge clk);
        mach_clr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((busy_a || busy_b) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(busy_a || busy_b), 0);
        @(negedge clk);
    endtask

    task automatic wait_ph1(input string nm);
        int k = 0;
        while (!x_a && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(x_a), 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc, bcnt, seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_hit",  int'(hit_a), 0);
        chk("rst_last", int'(last_a), 0);

        // Reset asserted mid-PH1, then a normal run after release.
        go(5, 10, 0);
        wait_ph1("rst_reach_ph1");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({x_a, step_en_a, busy_a, done_a, hit_a, last_a}), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Baseline: up-counter machine from 00, target 11.
        clr_mach();
        go(5, 10, 3);
        wait_done(cyc);
        chk("base_done_cycle", cyc, 17);
        chk("base_hit_cnt", int'(hit_a), 2);
        chk("base_last_ab", int'(last_a), 1);
        wait_idle("base_idle");

        // n0 = n1 = 0: GAP then DONE only.
        go(0, 0, 0);
        bcnt = 0; seen = 0;
        repeat (5) begin
            if (busy_a) bcnt++;
            if (step_en_a) seen = 1;
            @(negedge clk);
        end
        chk("zero_busy_cycles", bcnt, 2);
        chk("zero_step_en", seen, 0);
        chk("zero_hit_cnt", int'(hit_a), 0);
        wait_idle("zero_idle");

        // Abort on 3rd PH1 cycle, with a stray start pulse earlier.
        clr_mach();
        go(2, 8, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ph1("abort_reach_ph1");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_x", int'(x_a), 0);
        chk("abort_step_en", int'(step_en_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        seen = 0;
        repeat (6) begin
            if (done_a) seen = 1;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        wait_idle("abort_idle");

        // Saturation on the CNT_W=2 instance with a held machine state.
        ab_b = 2'd2;
        go(0, 3, 2);
        wait_idle("sat_idle");
        chk("sat_hit_cnt", int'(hit_b), 3);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy_a", int'(busy_a), 0);
        chk("start_abort_busy_b", int'(busy_b), 0);

        // Randomized traffic checked by the per-cycle compare.
        repeat (600) begin
            @(negedge clk);
            start  = ($urandom_range(0, 4) == 0);
            abort  = ($urandom_range(0, 40) == 0);
            n0     = 4'($urandom_range(0, 6));
            n1     = 4'($urandom_range(0, 6));
            target = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ab_b = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        wait_idle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
